// File: rtl/screen_pkg.sv
// Shared screen types for the VGA background path: screen ids, 12-bit pixel
// struct, fade range and the sequencer state encoding.
package screen_pkg;

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    GAME  = 2'd1,
    END   = 2'd2
  } screen_t;

  typedef enum logic [2:0] {
    ST_TITLE    = 3'd0,
    ST_GAME     = 3'd1,
    ST_END      = 3'd2,
    ST_FADE_OUT = 3'd3,
    ST_FADE_IN  = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam logic [4:0] FADE_MAX = 5'd16;

  // Scale one channel by level/16; saturates if level is ever driven above 16.
  function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [4:0] level);
    logic [8:0] prod;
    prod = {5'd0, c} * {4'd0, level};
    return prod[8] ? 4'hF : prod[7:4];
  endfunction

  function automatic state_t steady_state_of(input screen_t s);
    state_t st;
    case (s)
      TITLE:   st = ST_TITLE;
      GAME:    st = ST_GAME;
      END:     st = ST_END;
      default: st = ST_TITLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/screen_sequencer_rgb_fade.sv
// Combinational brightness scaler: each 4-bit channel multiplied by level/16,
// truncated (no rounding).
module rgb_fade
  import screen_pkg::*;
(
  input  rgb12_t     rgb_i,
  input  logic [4:0] level_i,
  output rgb12_t     rgb_o
);

  // Per-channel scaling.
  always_comb begin
    rgb_o   = '0;
    rgb_o.r = scale_chan(rgb_i.r, level_i);
    rgb_o.g = scale_chan(rgb_i.g, level_i);
    rgb_o.b = scale_chan(rgb_i.b, level_i);
  end

endmodule

// File: rtl/screen_sequencer.sv
// Title -> game -> end screen sequencer with frame-paced fade-out/fade-in,
// background source mux and the registered VGA colour outputs.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int FADE_STEP_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        blank,
  input  logic        start,
  input  logic        game_over,
  input  logic        restart,
  input  logic [11:0] title_rgb,
  input  logic [11:0] game_rgb,
  input  logic [11:0] end_rgb,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic [1:0]  screen_sel,
  output logic        busy
);

  localparam int CNT_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_STEP_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  screen_t          target_q, target_d;
  screen_t          sel_q, sel_d;
  logic [4:0]       level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rgb12_t           rgb_q, rgb_d;

  rgb12_t           mux_rgb_s;
  rgb12_t           faded_rgb_s;

  // Next-state logic for the screen flow and fade pacing.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sel_d    = sel_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_TITLE: begin
        if (start) begin
          target_d = GAME;
          state_d  = ST_FADE_OUT;
          cnt_d    = '0;
        end else begin
          state_d = ST_TITLE;
        end
      end
      ST_GAME: begin
        if (game_over) begin
          target_d = END;
          state_d  = ST_FADE_OUT;
          cnt_d    = '0;
        end else begin
          state_d = ST_GAME;
        end
      end
      ST_END: begin
        if (restart) begin
          target_d = TITLE;
          state_d  = ST_FADE_OUT;
          cnt_d    = '0;
        end else begin
          state_d = ST_END;
        end
      end
      ST_FADE_OUT: begin
        if (!frame_tick) begin
          state_d = ST_FADE_OUT;
        end else if (level_q == 5'd0) begin
          // Screen swaps only while fully dark.
          sel_d   = target_q;
          state_d = ST_FADE_IN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          level_d = level_q - 5'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FADE_IN: begin
        if (!frame_tick) begin
          state_d = ST_FADE_IN;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          level_d = level_q + 5'd1;
          if (level_q == FADE_MAX - 5'd1) begin
            state_d = steady_state_of(target_q);
          end else begin
            state_d = ST_FADE_IN;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d  = ST_TITLE;
        target_d = TITLE;
        sel_d    = TITLE;
        level_d  = FADE_MAX;
        cnt_d    = '0;
      end
    endcase
  end

  // Background source select by displayed screen.
  always_comb begin
    mux_rgb_s = '0;
    case (sel_q)
      TITLE:   mux_rgb_s = rgb12_t'(title_rgb);
      GAME:    mux_rgb_s = rgb12_t'(game_rgb);
      END:     mux_rgb_s = rgb12_t'(end_rgb);
      default: mux_rgb_s = '0;
    endcase
  end

  rgb_fade u_rgb_fade (
    .rgb_i   (mux_rgb_s),
    .level_i (level_q),
    .rgb_o   (faded_rgb_s)
  );

  // Blanking ahead of the output register.
  always_comb begin
    if (blank) begin
      rgb_d = faded_rgb_s;
    end else begin
      rgb_d = '0;
    end
  end

  // State, fade counters and pixel output registers.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_TITLE;
      target_q <= TITLE;
      sel_q    <= TITLE;
      level_q  <= FADE_MAX;
      cnt_q    <= '0;
      rgb_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sel_q    <= sel_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      rgb_q    <= rgb_d;
    end
  end

  assign red        = rgb_q.r;
  assign green      = rgb_q.g;
  assign blue       = rgb_q.b;
  assign screen_sel = sel_q;
  assign busy       = (state_q == ST_FADE_OUT) || (state_q == ST_FADE_IN);

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer: random pixels, ticks and requests
// checked against a tick-count model of the fade timeline.
module tb_screen_sequencer;
  import screen_pkg::*;

  localparam int F = 2;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        frame_tick = 1'b0, blank = 1'b0;
  logic        start = 1'b0, game_over = 1'b0, restart = 1'b0;
  logic [11:0] title_rgb = 12'h000, game_rgb = 12'h000, end_rgb = 12'h000;
  logic [3:0]  red, green, blue;
  logic [1:0]  screen_sel;
  logic        busy;

  screen_sequencer #(.FADE_STEP_FRAMES(F)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .frame_tick(frame_tick), .blank(blank),
    .start(start), .game_over(game_over), .restart(restart),
    .title_rgb(title_rgb), .game_rgb(game_rgb), .end_rgb(end_rgb),
    .red(red), .green(green), .blue(blue), .screen_sel(screen_sel), .busy(busy)
  );

  rgb12_t     sw_in;
  logic [4:0] sw_lvl;
  rgb12_t     sw_out;
  rgb_fade u_sweep (.rgb_i(sw_in), .level_i(sw_lvl), .rgb_o(sw_out));

  always #5 vga_clk = ~vga_clk;

  typedef struct packed {
    logic [11:0] rgb;
    logic [1:0]  sel;
    logic        bsy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  // Model: m_n = frame ticks counted since the accepted request (-1 = steady).
  int m_n   = -1;
  int m_cur = 0;
  int m_tgt = 0;

  function automatic int m_level();
    if (m_n < 0) return 16;
    if (m_n <= 16 * F) return 16 - m_n / F;
    return (m_n - 16 * F - 1) / F;
  endfunction

  function automatic logic [3:0] m_scale(input int c, input int l);
    return 4'((c * l) / 16);
  endfunction

  task automatic step(input bit s, input bit g, input bit r);
    logic [11:0] src;
    exp_t        e;
    int          l;
    bit          tk;
    @(negedge vga_clk);
    reset_n    = 1'b1;
    title_rgb  = 12'($urandom);
    game_rgb   = 12'($urandom);
    end_rgb    = 12'($urandom);
    blank      = ($urandom_range(0, 7) != 0);
    tk         = ($urandom_range(0, 2) == 0);
    frame_tick = tk;
    start      = s;
    game_over  = g;
    restart    = r;
    src = (m_cur == 0) ? title_rgb : (m_cur == 1) ? game_rgb : end_rgb;
    l = m_level();
    if (blank)
      e.rgb = {m_scale(int'(src[11:8]), l), m_scale(int'(src[7:4]), l), m_scale(int'(src[3:0]), l)};
    else
      e.rgb = 12'h000;
    if (m_n < 0) begin
      if ((m_cur == 0 && s) || (m_cur == 1 && g) || (m_cur == 2 && r)) begin
        m_n   = 0;
        m_tgt = (m_cur + 1) % 3;
      end
    end else if (tk) begin
      m_n++;
      if (m_n == 16 * F + 1) m_cur = m_tgt;
      if (m_n == 32 * F + 1) m_n = -1;
    end
    e.sel = 2'(m_cur);
    e.bsy = (m_n >= 0);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    exp_t z;
    z = '0;
    @(negedge vga_clk);
    start = 1'b0; game_over = 1'b0; restart = 1'b0; frame_tick = 1'b0;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({red, green, blue} !== 12'h000 || screen_sel !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_immediate: got rgb=%h sel=%0d busy=%0b, expected rgb=000 sel=0 busy=0",
               {red, green, blue}, screen_sel, busy);
    end
    m_n = -1; m_cur = 0; m_tgt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge vga_clk);
      exp_q.push_back(z);
    end
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while (m_n >= 0 && k < budget) begin
      step(1'b0, 1'b0, 1'b0);
      k++;
    end
    if (m_n >= 0) begin
      tests++;
      fails++;
      $display("FAIL fade_timeout: fade still running after %0d cycles, expected completion", budget);
    end
  endtask

  // Monitor: one expected entry per clock edge.
  always @(posedge vga_clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      tests++;
      if ({red, green, blue} !== mon_e.rgb || screen_sel !== mon_e.sel || busy !== mon_e.bsy) begin
        fails++;
        $display("FAIL output: got rgb=%h sel=%0d busy=%0b, expected rgb=%h sel=%0d busy=%0b",
                 {red, green, blue}, screen_sel, busy, mon_e.rgb, mon_e.sel, mon_e.bsy);
      end
    end
  end

  initial begin
    // Exhaustive scaler sweep on a standalone instance.
    for (int c = 0; c < 16; c++) begin
      for (int l = 0; l <= 16; l++) begin
        sw_in  = rgb12_t'({4'(c), 4'(15 - c), 4'(c)});
        sw_lvl = 5'(l);
        #1;
        tests++;
        if (sw_out.r !== m_scale(c, l) || sw_out.g !== m_scale(15 - c, l) || sw_out.b !== m_scale(c, l)) begin
          fails++;
          $display("FAIL scaler c=%0d level=%0d: got %h, expected r=b=%h g=%h",
                   c, l, sw_out, m_scale(c, l), m_scale(15 - c, l));
        end
      end
    end

    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);

    // All three requests at once in TITLE, then noise during the fade.
    step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 2000 && m_n >= 0; k++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    run_until_idle(2000);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_until_idle(2000);
    step(1'b0, 1'b0, 1'b1);
    run_until_idle(2000);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
    run_until_idle(2000);

    // Reset while fading out at level 5.
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2000 && !(m_n >= 0 && m_n <= 16 * F && m_level() == 5); k++)
      step(1'b0, 1'b0, 1'b0);
    tests++;
    if (!(m_n >= 0 && m_level() == 5)) begin
      fails++;
      $display("FAIL reach_level5: model level %0d, expected 5", m_level());
    end
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0);

    @(posedge vga_clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
